// File: rtl/fft_frame_streamer.sv
// Captures one parallel FFT result frame and replays its bins one per beat,
// in natural order, over a valid/ready stream tagged with bin index and last flag.
module fft_frame_streamer #(
    parameter int POINT_FFT_POW2 = 4,
    parameter int FRAC_BITS      = 15,
    localparam int POINT_FFT     = 1 << POINT_FFT_POW2
) (
    input  logic                                         clk_i,
    input  logic                                         rst_ni,
    input  logic signed [POINT_FFT-1:0][1:0][FRAC_BITS:0] frame_i,
    input  logic                                         frame_valid_i,
    output logic                                         frame_ready_o,
    output logic signed [FRAC_BITS:0]                    sample_re_o,
    output logic signed [FRAC_BITS:0]                    sample_im_o,
    output logic        [POINT_FFT_POW2-1:0]             sample_idx_o,
    output logic                                         sample_last_o,
    output logic                                         sample_valid_o,
    input  logic                                         sample_ready_i,
    output logic                                         busy_o
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam logic [POINT_FFT_POW2-1:0] LAST_IDX = POINT_FFT_POW2'(POINT_FFT - 1);

    state_t                                state;
    logic [POINT_FFT_POW2-1:0]             idx;
    logic [POINT_FFT-1:0][1:0][FRAC_BITS:0] buffer;
    logic                                  valid_q;

    logic fire;
    logic last_beat;
    logic capture;

    assign fire      = valid_q && sample_ready_i;
    assign last_beat = valid_q && (idx == LAST_IDX);

    // Ready also opens on the accepted last beat so the next frame follows with no bubble.
    assign frame_ready_o = (state == IDLE) || (fire && last_beat);
    assign capture       = frame_valid_i && frame_ready_o;

    assign sample_valid_o = valid_q;
    assign busy_o         = valid_q;
    assign sample_last_o  = last_beat;
    assign sample_idx_o   = idx;
    assign sample_re_o    = buffer[idx][0];
    assign sample_im_o    = buffer[idx][1];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state   <= IDLE;
            idx     <= '0;
            valid_q <= 1'b0;
            buffer  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (capture) begin
                        buffer  <= frame_i;
                        idx     <= '0;
                        valid_q <= 1'b1;
                        state   <= STREAM;
                    end
                end
                STREAM: begin
                    if (fire) begin
                        if (last_beat) begin
                            idx <= '0;
                            if (capture) begin
                                buffer <= frame_i;
                            end else begin
                                valid_q <= 1'b0;
                                state   <= IDLE;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    idx     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_streamer.sv
// Randomized and directed bench for fft_frame_streamer; expected beats come from
// the captured frames laid out in natural bin order.
module tb_fft_frame_streamer;

    localparam int POW2 = 4;
    localparam int N    = 1 << POW2;
    localparam int W    = 16;

    typedef logic [N-1:0][1:0][W-1:0] frame_t;

    logic                  clk;
    logic                  rst_n;
    frame_t                frame;
    logic                  frame_valid;
    logic                  frame_ready;
    logic signed [W-1:0]   sample_re;
    logic signed [W-1:0]   sample_im;
    logic [POW2-1:0]       sample_idx;
    logic                  sample_last;
    logic                  sample_valid;
    logic                  sample_ready;
    logic                  busy;

    int tests  = 0;
    int failed = 0;

    fft_frame_streamer #(.POINT_FFT_POW2(POW2), .FRAC_BITS(W-1)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .frame_i        (frame),
        .frame_valid_i  (frame_valid),
        .frame_ready_o  (frame_ready),
        .sample_re_o    (sample_re),
        .sample_im_o    (sample_im),
        .sample_idx_o   (sample_idx),
        .sample_last_o  (sample_last),
        .sample_valid_o (sample_valid),
        .sample_ready_i (sample_ready),
        .busy_o         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frames offered by the source and beats observed at the output.
    frame_t      frames_in [0:7];
    logic [W-1:0] obs_re   [0:127];
    logic [W-1:0] obs_im   [0:127];
    logic [POW2-1:0] obs_idx [0:127];
    logic        obs_last  [0:127];
    int obs_n, stable_err, bubble, rdy_bad, rdy_pulses, first_lat, valid_cycles;
    bit timeout;

    function automatic frame_t random_frame();
        frame_t f;
        for (int k = 0; k < N; k++) begin
            f[k][0] = W'($urandom);
            f[k][1] = W'($urandom);
        end
        return f;
    endfunction

    // mode 0: ready always high, 1: toggling 1,0,1,0..., 2: random
    task automatic run_frames(input int nframes, input int mode);
        int fi = 0;
        int cyc = 0;
        int cap_cyc = -1;
        bit prev_stall = 0;
        logic [W-1:0] pre = '0, pim = '0;
        logic [POW2-1:0] pidx = '0;
        logic plast = 0;
        obs_n = 0; stable_err = 0; bubble = 0; rdy_bad = 0; rdy_pulses = 0;
        first_lat = -1; valid_cycles = 0; timeout = 0;
        while (obs_n < nframes * N) begin
            @(negedge clk);
            cyc++;
            if (cyc > 3000) begin
                timeout = 1;
                break;
            end
            frame_valid = (fi < nframes);
            if (fi < nframes) frame = frames_in[fi];
            case (mode)
                0:       sample_ready = 1'b1;
                1:       sample_ready = (cyc % 2 == 1);
                default: sample_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (prev_stall && (sample_valid !== 1'b1 || sample_re !== pre || sample_im !== pim ||
                               sample_idx !== pidx || sample_last !== plast))
                stable_err++;
            if (sample_valid === 1'b1) begin
                valid_cycles++;
                if (first_lat < 0 && cap_cyc >= 0) first_lat = cyc - cap_cyc;
            end else if (obs_n > 0) begin
                bubble++;
            end
            if (frame_ready === 1'b1 && sample_valid === 1'b1) begin
                rdy_pulses++;
                if (!(sample_ready && sample_last === 1'b1)) rdy_bad++;
            end
            if (sample_valid === 1'b1 && sample_ready) begin
                obs_re[obs_n]   = sample_re;
                obs_im[obs_n]   = sample_im;
                obs_idx[obs_n]  = sample_idx;
                obs_last[obs_n] = sample_last;
                obs_n++;
            end
            prev_stall = (sample_valid === 1'b1) && !sample_ready;
            pre = sample_re; pim = sample_im; pidx = sample_idx; plast = sample_last;
            if (frame_valid && frame_ready === 1'b1) begin
                if (cap_cyc < 0) cap_cyc = cyc;
                fi++;
            end
        end
        @(negedge clk);
        frame_valid  = 1'b0;
        sample_ready = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; frame_valid = 1'b0; sample_ready = 1'b0; frame = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        tests++;
        if (sample_valid !== 1'b0 || sample_last !== 1'b0 || busy !== 1'b0 || frame_ready !== 1'b1) begin
            failed++;
            $display("FAIL reset_ctrl: valid=%b last=%b busy=%b ready=%b, required 0 0 0 1",
                     sample_valid, sample_last, busy, frame_ready);
        end
        tests++;
        if (sample_re !== 16'sd0 || sample_im !== 16'sd0 || sample_idx !== 4'd0) begin
            failed++;
            $display("FAIL reset_data: re=%h im=%h idx=%0d, required 0 0 0", sample_re, sample_im, sample_idx);
        end
    endtask

    task automatic test_dc_frame();
        frame_t f = '0;
        f[0][0] = 16'h4000;
        frames_in[0] = f;
        run_frames(1, 0);
        tests++;
        if (timeout || obs_n != N) begin
            failed++;
            $display("FAIL dc_count: got %0d beats (timeout=%0b), required %0d", obs_n, timeout, N);
        end
        tests++;
        if (first_lat != 1) begin
            failed++;
            $display("FAIL dc_latency: got %0d cycles, required 1", first_lat);
        end
        for (int b = 0; b < obs_n; b++) begin
            tests++;
            if (obs_idx[b] !== 4'(b) || obs_last[b] !== (b == N-1) ||
                obs_re[b] !== ((b == 0) ? 16'h4000 : 16'h0000) || obs_im[b] !== 16'h0000) begin
                failed++;
                $display("FAIL dc_beat%0d: idx=%0d last=%b re=%h im=%h, required idx=%0d last=%b re=%h im=0000",
                         b, obs_idx[b], obs_last[b], obs_re[b], obs_im[b], b, (b == N-1),
                         (b == 0) ? 16'h4000 : 16'h0000);
            end
        end
        repeat (2) @(negedge clk);
        tests++;
        if (sample_valid !== 1'b0 || busy !== 1'b0 || frame_ready !== 1'b1) begin
            failed++;
            $display("FAIL dc_idle_after: valid=%b busy=%b ready=%b, required 0 0 1", sample_valid, busy, frame_ready);
        end
    endtask

    task automatic test_tone_stall();
        frame_t f = '0;
        f[3][0]  = 16'h2000;
        f[13][0] = 16'h2000;
        frames_in[0] = f;
        run_frames(1, 1);
        tests++;
        if (timeout || obs_n != N || stable_err != 0 || bubble != 0) begin
            failed++;
            $display("FAIL tone_stream: beats=%0d timeout=%0b unstable=%0d bubbles=%0d, required %0d 0 0 0",
                     obs_n, timeout, stable_err, bubble, N);
        end
        for (int b = 0; b < obs_n; b++) begin
            tests++;
            if (obs_idx[b] !== 4'(b) || obs_re[b] !== f[b][0] || obs_im[b] !== 16'h0000 ||
                obs_last[b] !== (b == N-1)) begin
                failed++;
                $display("FAIL tone_beat%0d: idx=%0d re=%h im=%h last=%b, required idx=%0d re=%h im=0000",
                         b, obs_idx[b], obs_re[b], obs_im[b], obs_last[b], b, f[b][0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        frame_t a = '0, b = '0;
        for (int k = 0; k < N; k++) begin
            a[k][0] = 16'h0001;
            b[k][0] = 16'hFFFF;
        end
        frames_in[0] = a;
        frames_in[1] = b;
        run_frames(2, 0);
        tests++;
        if (timeout || obs_n != 2*N || valid_cycles != 2*N || bubble != 0) begin
            failed++;
            $display("FAIL b2b_stream: beats=%0d valid_cycles=%0d bubbles=%0d timeout=%0b, required %0d %0d 0 0",
                     obs_n, valid_cycles, bubble, timeout, 2*N, 2*N);
        end
        tests++;
        if (rdy_bad != 0 || rdy_pulses != 2) begin
            failed++;
            $display("FAIL b2b_ready: stray=%0d pulses=%0d, required 0 2", rdy_bad, rdy_pulses);
        end
        for (int i = 0; i < obs_n; i++) begin
            tests++;
            if (obs_idx[i] !== 4'(i % N) || obs_re[i] !== ((i < N) ? 16'h0001 : 16'hFFFF) ||
                obs_last[i] !== (i % N == N-1)) begin
                failed++;
                $display("FAIL b2b_beat%0d: idx=%0d re=%h last=%b, required idx=%0d re=%h",
                         i, obs_idx[i], obs_re[i], obs_last[i], i % N, (i < N) ? 16'h0001 : 16'hFFFF);
            end
        end
    endtask

    task automatic test_midstream_offer();
        int errs = 0;
        frames_in[0] = random_frame();
        frames_in[1] = random_frame();
        run_frames(2, 2);
        tests++;
        if (timeout || obs_n != 2*N || rdy_bad != 0 || rdy_pulses != 2 || stable_err != 0) begin
            failed++;
            $display("FAIL mid_offer: beats=%0d stray_ready=%0d pulses=%0d unstable=%0d timeout=%0b, required %0d 0 2 0 0",
                     obs_n, rdy_bad, rdy_pulses, stable_err, timeout, 2*N);
        end
        for (int i = 0; i < obs_n; i++)
            if (obs_re[i] !== frames_in[i/N][i%N][0] || obs_im[i] !== frames_in[i/N][i%N][1] ||
                obs_idx[i] !== 4'(i % N))
                errs++;
        tests++;
        if (errs != 0) begin
            failed++;
            $display("FAIL mid_data: %0d beats differ from the offered frames, required 0", errs);
        end
    endtask

    task automatic test_reset_midstream();
        int cyc = 0;
        int stray = 0;
        frame_t f = random_frame();
        @(negedge clk);
        frame = f; frame_valid = 1'b1; sample_ready = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
        while (!(sample_valid === 1'b1 && sample_idx === 4'd5) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        tests++;
        if (cyc >= 50) begin
            failed++;
            $display("FAIL rstmid_reach: beat 5 not seen within 50 cycles");
        end
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        tests++;
        if (sample_valid !== 1'b0 || frame_ready !== 1'b1 || busy !== 1'b0) begin
            failed++;
            $display("FAIL rstmid_state: valid=%b ready=%b busy=%b, required 0 1 0", sample_valid, frame_ready, busy);
        end
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (sample_valid !== 1'b0) stray++;
        end
        tests++;
        if (stray != 0) begin
            failed++;
            $display("FAIL rstmid_stray: %0d beats of the abandoned frame, required 0", stray);
        end
        frames_in[0] = random_frame();
        run_frames(1, 0);
        tests++;
        if (timeout || obs_n != N || obs_idx[0] !== 4'd0 || obs_re[0] !== frames_in[0][0][0] ||
            obs_re[N-1] !== frames_in[0][N-1][0] || obs_im[N-1] !== frames_in[0][N-1][1]) begin
            failed++;
            $display("FAIL rstmid_restart: beats=%0d idx0=%0d re0=%h, required %0d 0 %h",
                     obs_n, obs_idx[0], obs_re[0], N, frames_in[0][0][0]);
        end
    endtask

    task automatic test_signed_extremes();
        frame_t f = random_frame();
        f[7][0] = 16'h8000;
        f[7][1] = 16'h7FFF;
        frames_in[0] = f;
        run_frames(1, 2);
        tests++;
        if (timeout || obs_n != N || $signed(obs_re[7]) != -32768 || $signed(obs_im[7]) != 32767) begin
            failed++;
            $display("FAIL signed_bin7: re=%0d im=%0d beats=%0d, required -32768 32767 %0d",
                     $signed(obs_re[7]), $signed(obs_im[7]), obs_n, N);
        end
    endtask

    task automatic test_random_stream();
        int errs = 0;
        for (int i = 0; i < 4; i++) frames_in[i] = random_frame();
        run_frames(4, 2);
        tests++;
        if (timeout || obs_n != 4*N || stable_err != 0 || bubble != 0 || rdy_bad != 0) begin
            failed++;
            $display("FAIL rand_stream: beats=%0d unstable=%0d bubbles=%0d stray_ready=%0d timeout=%0b, required %0d 0 0 0 0",
                     obs_n, stable_err, bubble, rdy_bad, timeout, 4*N);
        end
        for (int i = 0; i < obs_n; i++)
            if (obs_re[i] !== frames_in[i/N][i%N][0] || obs_im[i] !== frames_in[i/N][i%N][1] ||
                obs_idx[i] !== 4'(i % N) || obs_last[i] !== (i % N == N-1))
                errs++;
        tests++;
        if (errs != 0) begin
            failed++;
            $display("FAIL rand_data: %0d beats differ from the reference, required 0", errs);
        end
    endtask

    initial begin
        rst_n = 1'b0; frame = '0; frame_valid = 1'b0; sample_ready = 1'b0;
        test_reset();
        test_dc_frame();
        test_tone_stall();
        test_back_to_back();
        test_midstream_offer();
        test_reset_midstream();
        test_signed_extremes();
        test_random_stream();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
